// File: rtl/win_checker.sv
// rtl/win_checker.sv - Connect Four shadow board and four-in-a-row scanner
module win_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       go,
    input  logic [2:0] col_addr,
    input  logic [5:0] col_onoff,
    input  logic [5:0] col_player,
    input  logic       player,
    output logic       busy,
    output logic       done,
    output logic       game_over,
    output logic       draw,
    output logic [2:0] win_col,
    output logic [2:0] win_row,
    output logic [1:0] win_dir
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Board cells are flattened as bit index col*6 + row.
    logic [41:0] onoff_q, onoff_d;
    logic [41:0] owner_q, owner_d;
    logic        player_q, player_d;
    logic [5:0]  k_q, k_d;
    logic [2:0]  acol_q, acol_d;
    logic [2:0]  arow_q, arow_d;
    logic        game_over_q, game_over_d;
    logic        draw_q, draw_d;
    logic [2:0]  win_col_q, win_col_d;
    logic [2:0]  win_row_q, win_row_d;
    logic [1:0]  win_dir_q, win_dir_d;

    // Zero padding lets every window index past the board read as empty,
    // so the bounds checks below only have to reject wrap-around cases.
    logic [63:0] mine_ext;
    logic        hit_r, hit_u, hit_ur, hit_dr, any_hit;
    logic [1:0]  hit_dir;

    assign mine_ext = {22'b0, onoff_q & ~(owner_q ^ {42{player_q}})};

    assign hit_r  = (acol_q <= 3'd3) &&
                    mine_ext[k_q] && mine_ext[k_q + 6'd6] &&
                    mine_ext[k_q + 6'd12] && mine_ext[k_q + 6'd18];
    assign hit_u  = (arow_q <= 3'd2) &&
                    mine_ext[k_q] && mine_ext[k_q + 6'd1] &&
                    mine_ext[k_q + 6'd2] && mine_ext[k_q + 6'd3];
    assign hit_ur = (acol_q <= 3'd3) && (arow_q <= 3'd2) &&
                    mine_ext[k_q] && mine_ext[k_q + 6'd7] &&
                    mine_ext[k_q + 6'd14] && mine_ext[k_q + 6'd21];
    assign hit_dr = (acol_q <= 3'd3) && (arow_q >= 3'd3) &&
                    mine_ext[k_q] && mine_ext[k_q + 6'd5] &&
                    mine_ext[k_q + 6'd10] && mine_ext[k_q + 6'd15];

    assign any_hit = hit_r | hit_u | hit_ur | hit_dr;

    always_comb begin
        hit_dir = 2'd3;
        if (hit_r) begin
            hit_dir = 2'd0;
        end else if (hit_u) begin
            hit_dir = 2'd1;
        end else if (hit_ur) begin
            hit_dir = 2'd2;
        end
    end

    always_comb begin
        state_d     = state_q;
        onoff_d     = onoff_q;
        owner_d     = owner_q;
        player_d    = player_q;
        k_d         = k_q;
        acol_d      = acol_q;
        arow_d      = arow_q;
        game_over_d = game_over_q;
        draw_d      = draw_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        win_dir_d   = win_dir_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    for (int c = 0; c < 7; c++) begin
                        if (col_addr == 3'(c)) begin
                            onoff_d[c*6 +: 6] = col_onoff;
                            owner_d[c*6 +: 6] = col_player;
                        end
                    end
                    player_d    = player;
                    k_d         = 6'd0;
                    acol_d      = 3'd0;
                    arow_d      = 3'd0;
                    game_over_d = 1'b0;
                    draw_d      = 1'b0;
                    win_col_d   = 3'd0;
                    win_row_d   = 3'd0;
                    win_dir_d   = 2'd0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (any_hit) begin
                    win_col_d   = acol_q;
                    win_row_d   = arow_q;
                    win_dir_d   = hit_dir;
                    game_over_d = 1'b1;
                    state_d     = S_DONE;
                end else if (k_q == 6'd41) begin
                    game_over_d = &onoff_q;
                    draw_d      = &onoff_q;
                    state_d     = S_DONE;
                end else begin
                    k_d = k_q + 6'd1;
                    if (arow_q == 3'd5) begin
                        arow_d = 3'd0;
                        acol_d = acol_q + 3'd1;
                    end else begin
                        arow_d = arow_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state_q     <= S_IDLE;
            onoff_q     <= '0;
            owner_q     <= '0;
            player_q    <= 1'b0;
            k_q         <= '0;
            acol_q      <= '0;
            arow_q      <= '0;
            game_over_q <= 1'b0;
            draw_q      <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            win_dir_q   <= '0;
        end else begin
            state_q     <= state_d;
            onoff_q     <= onoff_d;
            owner_q     <= owner_d;
            player_q    <= player_d;
            k_q         <= k_d;
            acol_q      <= acol_d;
            arow_q      <= arow_d;
            game_over_q <= game_over_d;
            draw_q      <= draw_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            win_dir_q   <= win_dir_d;
        end
    end

    assign busy      = (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign game_over = game_over_q;
    assign draw      = draw_q;
    assign win_col   = win_col_q;
    assign win_row   = win_row_q;
    assign win_dir   = win_dir_q;

endmodule

// File: tb/tb_win_checker.sv
// tb/tb_win_checker.sv - randomized bench for win_checker against a board model
module tb_win_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       go = 1'b0;
    logic [2:0] col_addr = 3'd7;
    logic [5:0] col_onoff = '0;
    logic [5:0] col_player = '0;
    logic       player = 1'b0;
    logic       busy, done, game_over, draw;
    logic [2:0] win_col, win_row;
    logic [1:0] win_dir;

    int n_checks = 0;
    int n_fail = 0;

    bit m_on [7][6];
    bit m_own[7][6];

    win_checker dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .go        (go),
        .col_addr  (col_addr),
        .col_onoff (col_onoff),
        .col_player(col_player),
        .player    (player),
        .busy      (busy),
        .done      (done),
        .game_over (game_over),
        .draw      (draw),
        .win_col   (win_col),
        .win_row   (win_row),
        .win_dir   (win_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) begin
                m_on[c][r]  = 1'b0;
                m_own[c][r] = 1'b0;
            end
    endtask

    // Scans anchors in column-major order; returns first hit (k=-1 if none).
    task automatic model_scan(input bit p, output int k_hit, output int d_hit, output bit full);
        int dx[4] = '{1, 0, 1, 1};
        int dy[4] = '{0, 1, 1, -1};
        k_hit = -1;
        d_hit = 0;
        full  = 1'b1;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                if (!m_on[c][r]) full = 1'b0;
        for (int k = 0; k < 42 && k_hit < 0; k++) begin
            for (int d = 0; d < 4 && k_hit < 0; d++) begin
                bit ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    int cc = k / 6 + dx[d] * i;
                    int rr = k % 6 + dy[d] * i;
                    if (cc < 0 || cc > 6 || rr < 0 || rr > 5) ok = 1'b0;
                    else if (!m_on[cc][rr] || m_own[cc][rr] != p) ok = 1'b0;
                end
                if (ok) begin
                    k_hit = k;
                    d_hit = d;
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_draw"}, draw, 0);
        check({tag, "_win"}, {win_col, win_row, win_dir}, 0);
    endtask

    // extra_at: edge offset of an ignored second go; abort_at: edge offset of clear/reset.
    task automatic do_move(input logic [2:0] c, input logic [5:0] on_v, input logic [5:0] own_v,
                           input logic p, input int extra_at, input int abort_at, input bit use_rst);
        int  kh, dh, exp_n, got_n;
        bit  full, exp_go, exp_draw;
        if (c != 3'd7)
            for (int r = 0; r < 6; r++) begin
                m_on[c][r]  = on_v[r];
                m_own[c][r] = own_v[r];
            end
        model_scan(p, kh, dh, full);
        exp_n    = (kh >= 0) ? 2 + kh : 43;
        exp_go   = (kh >= 0) || full;
        exp_draw = (kh < 0) && full;

        @(negedge clk);
        go = 1'b1; col_addr = c; col_onoff = on_v; col_player = own_v; player = p;
        got_n = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                go = 1'b0;
                check("busy_after_go", busy, 1);
            end
            if (extra_at > 0 && n == extra_at) go = 1'b0;
            if (extra_at > 0 && n == extra_at - 1) begin
                go = 1'b1; col_addr = 3'd0; col_onoff = 6'b001111;
                col_player = 6'b001111; player = 1'b1;
            end
            if (abort_at > 0 && n == abort_at - 1) begin
                if (use_rst) reset = 1'b0; else clear = 1'b1;
            end
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b1;
                clear = 1'b0;
                model_clear();
                check_zero("after_abort");
                for (int j = 0; j < 45; j++) begin
                    @(negedge clk);
                    if (done) got_n = n + 1 + j;
                end
                check("no_done_after_abort", got_n, -1);
                return;
            end
            if (done) begin
                got_n = n;
                break;
            end
        end
        check("latency", got_n, exp_n);
        check("busy_at_done", busy, 0);
        check("game_over", game_over, exp_go);
        check("draw", draw, exp_draw);
        if (kh >= 0) begin
            check("win_col", win_col, kh / 6);
            check("win_row", win_row, kh % 6);
            check("win_dir", win_dir, dh);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("done_single_pulse", done, 0);
        end
        check("game_over_hold", game_over, exp_go);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        check_zero("clear");
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset_release");

        // Vertical win in column 2, anchor k=12
        do_move(3'd2, 6'b001111, 6'b001111, 1'b1, 0, 0, 0);
        check("vert_win_col", win_col, 2);

        // Horizontal win on row 0, columns 3-6
        do_clear();
        for (int c = 3; c <= 6; c++) do_move(3'(c), 6'b000001, 6'b000000, 1'b0, 0, 0, 0);
        check("horiz_win_dir", win_dir, 0);

        // Same line owned by player 1, but player 0 moves
        do_clear();
        for (int c = 3; c <= 6; c++) do_move(3'(c), 6'b000001, 6'b000001, 1'b0, 0, 0, 0);
        check("wrong_player_no_win", game_over, 0);

        // Full board with no four-in-a-row
        do_clear();
        for (int c = 0; c < 7; c++) begin
            logic [5:0] own = '0;
            for (int r = 0; r < 6; r++) own[r] = 1'((r / 2 + c) % 2);
            do_move(3'(c), 6'b111111, own, 1'(c % 2), 0, 0, 0);
        end
        check("draw_flag", draw, 1);
        check("draw_game_over", game_over, 1);

        // Second go at T+5 is ignored; a col-7 go then shows column 0 untouched
        do_clear();
        do_move(3'd3, 6'b000001, 6'b000000, 1'b0, 5, 0, 0);
        do_move(3'd7, 6'b000000, 6'b000000, 1'b1, 0, 0, 0);

        // Clear mid-scan, then a single-cell move
        do_move(3'd4, 6'b000011, 6'b000001, 1'b1, 0, 10, 0);
        do_move(3'd0, 6'b000001, 6'b000000, 1'b0, 0, 0, 0);

        // Randomized moves on an evolving board
        do_clear();
        for (int t = 0; t < 30; t++) begin
            logic [2:0] rc = 3'($urandom_range(0, 7));
            logic [5:0] ro = 6'($urandom);
            logic [5:0] rp = 6'($urandom);
            if (t % 10 == 0) do_clear();
            do_move(rc, ro, rp, 1'($urandom), 0, 0, 0);
        end

        // Reset mid-scan behaves like clear
        do_move(3'd1, 6'b000111, 6'b000000, 1'b0, 0, 7, 1);
        do_move(3'd7, 6'b000000, 6'b000000, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/win_checker.md
# win_checker

Game-logic unit for the Connect Four datapath. It keeps a shadow copy of the 7x6 on/off and player boards, and is updated one column per accepted move from the same column write values the control FSM sends to board memory. After each update it scans every cell for four-in-a-row owned by the moving player. It reports win, draw or continue to the control FSM through a go/done handshake, and reports the winning line's anchor and direction for the VGA highlighter.

## Interface
Parameters:
- none; board fixed at 7 columns x 6 rows.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- clear  in  1  synchronous board clear, active-high (driven by FSM logic_reset)
- go  in  1  one-cycle move strobe (FSM logic_go)
- col_addr  in  3  column written, 0-6; 7 = no column
- col_onoff  in  6  new on/off column value, bit r = row r, row 0 bottom
- col_player  in  6  new player column value, same bit order
- player  in  1  player who made the move
- busy  out  1  scan in progress
- done  out  1  one-cycle result strobe
- game_over  out  1  win or draw found by last scan
- draw  out  1  board full with no win
- win_col  out  3  winning line anchor column
- win_row  out  3  winning line anchor row
- win_dir  out  2  0=right, 1=up, 2=up-right, 3=down-right

## Operation
- Shadow state: onoff[7][6] and owner[7][6] registers, plus a latched copy of the mover.
- States:
  - IDLE: waits for a move.
  - SCAN: checks one anchor cell per cycle.
  - DONE: outputs the result for one cycle, then returns to IDLE.
- IDLE, go=1:
  - If col_addr is 0-6, overwrite onoff[col_addr] with col_onoff and owner[col_addr] with col_player.
  - If col_addr is 7, leave the board unchanged.
  - Latch player, clear the anchor counter, clear game_over/draw/win_*, and enter SCAN.
- SCAN order: anchor index k=0..41, col=k/6, row=k%6, row increments fastest.
- Per anchor, test four windows combinationally: (c,r)..(c+3,r); (c,r)..(c,r+3); (c+i,r+i); (c+i,r-i).
  - A window whose cells leave the board is false.
  - A window hits when all 4 cells are on and all 4 owners equal the latched player.
  - If several directions hit, the lowest win_dir wins.
- First hit:
  - Latch win_col/row/dir, set game_over=1, enter DONE.
  - Later anchors are not evaluated.
- No hit after k=41:
  - If all 42 onoff bits are set: draw=1, game_over=1.
  - Otherwise game_over=0.
  - Enter DONE.
- DONE: done=1 for one cycle, then IDLE.
- Result hold: game_over, draw and win_* hold until the next accepted go, clear or reset.
- go outside IDLE is ignored and does not queue.
- clear (any state):
  - Zero the board and all outputs, go to IDLE, no done pulse.
  - clear has priority over a simultaneous go.
- reset=0 behaves identically to clear.

## Timing
- Reset values: busy=0, done=0, game_over=0, draw=0, win_col=0, win_row=0, win_dir=0; board all zero; state IDLE.
- go sampled at edge T:
  - Board holds the new column from T+1.
  - busy=1 from T+1.
  - Anchor k is evaluated in cycle T+1+k.
- Win at anchor k:
  - DONE in cycle T+2+k: done=1, busy=0, results valid.
  - Minimum latency 2 cycles (k=0).
- No win: done in cycle T+43; that is the maximum latency.
- Results are valid in the done cycle and afterwards, per the hold rule.
- Earliest next accepted go: the cycle after done.
- clear at edge C: all outputs zero from C+1; a scan in flight is abandoned.

## Test plan
- Vertical win, column 2:
  - Stimulus: player 1 moves by go with col_addr=2, col_onoff=6'b001111, col_player=6'b001111.
  - Response: done at T+14 (anchor k=12), game_over=1, draw=0, win_col=2, win_row=0, win_dir=1.
- Horizontal win, row 0:
  - Stimulus: player 0 builds columns 3-6 with row 0 on and owner 0; the final go is col_addr=6.
  - Response: done=1, game_over=1, win_col=3, win_row=0, win_dir=0, at T+2+18.
- No win, move by the wrong player:
  - Stimulus: the same four-cell line is owned by player 1, but the final go has player=0.
  - Response: done at T+43, game_over=0.
- Draw:
  - Stimulus: fill all 7 columns with onoff=6'b111111 in a pattern with no four-in-a-row in any direction.
  - Response: the final done has game_over=1, draw=1.
- Handshake:
  - Stimulus: a second go at T+5 during a scan.
  - Response: it is ignored, the board is unchanged by it, and exactly one done pulse occurs.
- Clear mid-scan:
  - Stimulus: clear=1 at T+10.
  - Response: busy=0, game_over=0, no done pulse, board zero; the next go with col_addr=0, col_onoff=6'b000001 yields game_over=0.
